// File: rtl/tc_pl_cap_pkg.sv
// Shared types and default sizes for the merged-ADC capture producer.
package tc_pl_cap_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned ADC_W_DEF   = 28;
  localparam int unsigned ADC0_1_DEF  = 2 * ADC_W_DEF;
  localparam int unsigned FIFO_AW_DEF = 4;
  localparam int unsigned FIFO_DEPTH  = 1 << FIFO_AW_DEF;

endpackage

// File: rtl/tc_pl_cap_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with synchronous flush and occupancy count.
module tc_pl_cap_fifo_fwft
  import tc_pl_cap_pkg::*;
#(
  parameter int unsigned W  = ADC0_1_DEF,
  parameter int unsigned AW = FIFO_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  // Head word is shown only while something is queued; zero otherwise.
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !rd_en) begin
        level <= level + (AW+1)'(1);
      end else if (rd_en && !wr_en) begin
        level <= level - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/tc_pl_cap_data_adc_merge.sv
// Pairs ADC channel 0/1 samples into {ch1, ch0} words and queues them for the capture consumer.
module tc_pl_cap_data_adc_merge
  import tc_pl_cap_pkg::*;
#(
  parameter int unsigned ADC_W   = ADC_W_DEF,
  parameter int unsigned ADC0_1  = ADC0_1_DEF,
  parameter int unsigned FIFO_AW = FIFO_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_en,
  input  logic [ADC_W-1:0]   adc0_data,
  input  logic               adc0_valid,
  input  logic [ADC_W-1:0]   adc1_data,
  input  logic               adc1_valid,
  input  logic               Gc_cap_cmpt,
  output logic [ADC0_1-1:0]  Gc_merge_data,
  output logic               Gc_mereg_datv,
  input  logic               Gc_mereg_datr,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               ovf,
  output logic               skew_err
);

  state_t             state;
  logic               h0;
  logic               h1;
  logic [ADC_W-1:0]   r0;
  logic [ADC_W-1:0]   r1;

  logic               run_c;
  logic               cmpt_c;
  logic               pair_c;
  logic               pop_c;
  logic               drop_c;
  logic               flush_c;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ADC_W-1:0]   ch0_c;
  logic [ADC_W-1:0]   ch1_c;
  logic [ADC0_1-1:0]  merged_c;

  // Pair detection: a fresh strobe wins over the held copy of the same channel.
  always_comb begin
    run_c    = (state == S_RUN) && cap_en;
    cmpt_c   = run_c && Gc_cap_cmpt;
    pair_c   = run_c && !Gc_cap_cmpt && (h0 || adc0_valid) && (h1 || adc1_valid);
    ch0_c    = adc0_valid ? adc0_data : r0;
    ch1_c    = adc1_valid ? adc1_data : r1;
    merged_c = ADC0_1'({ch1_c, ch0_c});
    pop_c    = Gc_mereg_datv && Gc_mereg_datr;
    drop_c   = pair_c && fifo_full && !pop_c;
    flush_c  = !cap_en || cmpt_c;
  end

  assign Gc_mereg_datv = ~fifo_empty;

  tc_pl_cap_fifo_fwft #(
    .W  (ADC0_1),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_c),
    .push  (pair_c),
    .pop   (pop_c),
    .din   (merged_c),
    .dout  (Gc_merge_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Capture FSM, channel hold registers and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst || !cap_en) begin
      state    <= S_IDLE;
      h0       <= 1'b0;
      h1       <= 1'b0;
      r0       <= '0;
      r1       <= '0;
      ovf      <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_RUN;
        S_RUN: begin
          if (Gc_cap_cmpt) begin
            state <= S_DONE;
            h0    <= 1'b0;
            h1    <= 1'b0;
          end else if (pair_c) begin
            h0 <= 1'b0;
            h1 <= 1'b0;
            if (drop_c) begin
              ovf <= 1'b1;
            end
          end else begin
            if (adc0_valid) begin
              r0 <= adc0_data;
              h0 <= 1'b1;
              if (h0) begin
                skew_err <= 1'b1;
              end
            end
            if (adc1_valid) begin
              r1 <= adc1_data;
              h1 <= 1'b1;
              if (h1) begin
                skew_err <= 1'b1;
              end
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_data_adc_merge.sv
// Scoreboard bench for the merged-ADC capture producer.
module tb_tc_pl_cap_data_adc_merge;

  localparam int unsigned AW  = 28;
  localparam int unsigned MW  = 56;
  localparam int unsigned DEP = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           cap_en;
  logic [AW-1:0]  adc0_data;
  logic           adc0_valid;
  logic [AW-1:0]  adc1_data;
  logic           adc1_valid;
  logic           Gc_cap_cmpt;
  logic [MW-1:0]  Gc_merge_data;
  logic           Gc_mereg_datv;
  logic           Gc_mereg_datr;
  logic [4:0]     fifo_level;
  logic           ovf;
  logic           skew_err;

  always #5 clk = ~clk;

  tc_pl_cap_data_adc_merge dut (
    .clk           (clk),
    .rst           (rst),
    .cap_en        (cap_en),
    .adc0_data     (adc0_data),
    .adc0_valid    (adc0_valid),
    .adc1_data     (adc1_data),
    .adc1_valid    (adc1_valid),
    .Gc_cap_cmpt   (Gc_cap_cmpt),
    .Gc_merge_data (Gc_merge_data),
    .Gc_mereg_datv (Gc_mereg_datv),
    .Gc_mereg_datr (Gc_mereg_datr),
    .fifo_level    (fifo_level),
    .ovf           (ovf),
    .skew_err      (skew_err)
  );

  // Reference model: words the consumer should see, in order, plus pending samples.
  logic [MW-1:0] sb_q[$];
  bit            p0, p1;
  logic [AW-1:0] pv0, pv1;
  bit            e_ovf, e_skew;
  int            mode;   // 0 waiting for enable, 1 capturing, 2 capture finished
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: every accepted pop must match the oldest expected word.
  always @(negedge clk) begin
    logic [MW-1:0] ew;
    if (Gc_mereg_datv === 1'b1 && Gc_mereg_datr === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("pop_expected", 64'(sb_q.size() > 0), 64'd1);
      end else begin
        ew = sb_q.pop_front();
        chk("pop_data", 64'(Gc_merge_data), 64'(ew));
      end
    end
  end

  // One clock of stimulus: drive inputs, advance the model, then check visible state.
  task automatic cyc(input bit r, input bit ce, input bit v0, input logic [AW-1:0] d0,
                     input bit v1, input logic [AW-1:0] d1, input bit cm, input bit dr);
    bit pop;
    logic [AW-1:0] w0, w1;
    if (r || !ce || (mode == 1 && cm)) dr = 1'b0;
    rst = r; cap_en = ce; adc0_valid = v0; adc0_data = d0;
    adc1_valid = v1; adc1_data = d1; Gc_cap_cmpt = cm; Gc_mereg_datr = dr;
    pop = (sb_q.size() > 0) && dr;
    if (r || !ce) begin
      sb_q.delete(); p0 = 0; p1 = 0; e_ovf = 0; e_skew = 0; mode = 0;
    end else if (mode == 0) begin
      mode = 1;
    end else if (mode == 1) begin
      if (cm) begin
        sb_q.delete(); p0 = 0; p1 = 0; mode = 2;
      end else if ((v0 || p0) && (v1 || p1)) begin
        w0 = v0 ? d0 : pv0;
        w1 = v1 ? d1 : pv1;
        if (sb_q.size() < DEP || pop) sb_q.push_back({w1, w0});
        else e_ovf = 1;
        p0 = 0; p1 = 0;
      end else begin
        if (v0) begin if (p0) e_skew = 1; p0 = 1; pv0 = d0; end
        if (v1) begin if (p1) e_skew = 1; p1 = 1; pv1 = d1; end
      end
    end
    @(posedge clk); #1;
    chk("level", 64'(fifo_level), 64'(sb_q.size()));
    chk("datv", 64'(Gc_mereg_datv), 64'(sb_q.size() > 0));
    chk("ovf", 64'(ovf), 64'(e_ovf));
    chk("skew_err", 64'(skew_err), 64'(e_skew));
    if (sb_q.size() > 0) chk("head_data", 64'(Gc_merge_data), 64'(sb_q[0]));
    else chk("empty_data", 64'(Gc_merge_data), 64'd0);
  endtask

  task automatic run(input bit v0, input logic [AW-1:0] d0, input bit v1,
                     input logic [AW-1:0] d1, input bit dr);
    cyc(1'b0, 1'b1, v0, d0, v1, d1, 1'b0, dr);
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) run(1'b0, '0, 1'b0, '0, dr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mode = 0; p0 = 0; p1 = 0; pv0 = '0; pv1 = '0; e_ovf = 0; e_skew = 0;
    cyc(1, 0, 0, '0, 0, '0, 0, 0);
    cyc(1, 0, 0, '0, 0, '0, 0, 0);
    chk("rst_level_lit", 64'(fifo_level), 64'd0);
    run(0, '0, 0, '0, 0);                       // leave idle

    // Simultaneous pair, consumer ready.
    run(1, 28'h0000001, 1, 28'h0000002, 1);
    chk("t1_word_lit", 64'(Gc_merge_data), 64'h00000020000001);
    chk("t1_datv_lit", 64'(Gc_mereg_datv), 64'd1);
    run(0, '0, 0, '0, 1);
    chk("t1_datv_drop_lit", 64'(Gc_mereg_datv), 64'd0);

    // Channels three cycles apart.
    run(1, 28'hAAAAAAA, 0, '0, 0);
    idle(2, 0);
    run(0, '0, 1, 28'h5555555, 0);
    chk("t2_word_lit", 64'(Gc_merge_data), 64'h5555555AAAAAAA);
    chk("t2_skew_lit", 64'(skew_err), 64'd0);
    idle(2, 1);

    // Overflow: 17 pairs against a stalled consumer.
    for (int i = 0; i < 17; i++) run(1, AW'(i), 1, AW'(i + 'h100), 0);
    chk("t3_full_lit", 64'(fifo_level), 64'd16);
    chk("t3_ovf_lit", 64'(ovf), 64'd1);
    idle(20, 1);
    chk("t3_empty_lit", 64'(fifo_level), 64'd0);

    // Channel 0 overwritten before its partner arrives.
    run(1, 28'h1, 0, '0, 0);
    run(1, 28'h2, 0, '0, 0);
    run(0, '0, 1, 28'h3, 0);
    chk("t4_skew_lit", 64'(skew_err), 64'd1);
    chk("t4_word_lit", 64'(Gc_merge_data), 64'h00000030000002);
    idle(2, 1);

    // Capture complete flushes and freezes until re-enabled.
    for (int i = 0; i < 5; i++) run(1, AW'(i + 'h40), 1, AW'(i + 'h50), 0);
    cyc(0, 1, 0, '0, 0, '0, 1, 0);
    chk("t5_datv_lit", 64'(Gc_mereg_datv), 64'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, AW'(i), 1, AW'(i), 1, 1);
    cyc(0, 0, 0, '0, 0, '0, 0, 0);
    cyc(0, 1, 0, '0, 0, '0, 0, 0);
    run(1, 28'h123, 1, 28'h456, 0);
    chk("t5_resume_lit", 64'(Gc_merge_data), 64'h00004560000123);
    idle(2, 1);

    // Reset with words queued and channel 0 held.
    for (int i = 0; i < 3; i++) run(1, AW'(i + 7), 1, AW'(i + 9), 0);
    run(1, 28'hDEAD, 0, '0, 0);
    cyc(1, 1, 0, '0, 0, '0, 0, 0);
    chk("t6_rst_datv_lit", 64'(Gc_mereg_datv), 64'd0);
    run(0, '0, 0, '0, 0);
    run(0, '0, 1, 28'h77, 0);
    run(1, 28'h66, 0, '0, 0);
    chk("t6_word_lit", 64'(Gc_merge_data), 64'h00000770000066);
    idle(2, 1);

    // Randomized traffic with occasional completion, disable and reset.
    for (int i = 0; i < 2500; i++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 119) != 0,
          $urandom_range(0, 9) < 4, AW'($urandom),
          $urandom_range(0, 9) < 4, AW'($urandom),
          $urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6);
    end

    // Leave any finished capture and drain what remains.
    cyc(0, 0, 0, '0, 0, '0, 0, 0);
    cyc(0, 1, 0, '0, 0, '0, 0, 0);
    run(1, 28'hBEEF, 1, 28'hCAFE, 1);
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) run(0, '0, 0, '0, 1);
    chk("drain", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tc_pl_cap_data_adc_merge.md
Name: tc_pl_cap_data_adc_merge

Overview:
- Producer end of the merged-ADC capture handshake. It pairs one sample from ADC channel 0 with one from channel 1 and packs each pair into one ADC0_1-bit word.
- Pairs are buffered in a small first-word-fall-through FIFO and offered downstream on Gc_merge_data with Gc_mereg_datv; the downstream side pops with Gc_mereg_datr.
- Sits between the ADC interface and the capture buffer controller. When Gc_cap_cmpt reports the capture is finished, the block stops and flushes.

Parameters:
- ADC_W, 28, width of one ADC channel sample.
- ADC0_1, 56, merged word width; must equal 2*ADC_W.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cap_en  in  1  capture enable; low = clear and idle.
- adc0_data  in  ADC_W  channel 0 sample.
- adc0_valid  in  1  channel 0 sample strobe, one cycle per sample.
- adc1_data  in  ADC_W  channel 1 sample.
- adc1_valid  in  1  channel 1 sample strobe.
- Gc_cap_cmpt  in  1  level, from consumer: capture complete.
- Gc_merge_data  out  ADC0_1  merged word {ch1, ch0}.
- Gc_mereg_datv  out  1  merged word valid.
- Gc_mereg_datr  in  1  consumer ready.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- ovf  out  1  sticky: pair dropped because the FIFO was full.
- skew_err  out  1  sticky: a channel sample was overwritten before it found its partner.

Behaviour:
- Reset and clear: rst=1, or cap_en=0, synchronously returns the block to this state:
  - state S_IDLE;
  - hold flags h0 and h1 cleared;
  - FIFO pointers zeroed;
  - fifo_level=0, Gc_mereg_datv=0, ovf=0, skew_err=0;
  - Gc_merge_data=0 while the FIFO is empty.
- State machine (2-bit):
  - S_IDLE -> S_RUN when cap_en=1.
  - S_RUN -> S_DONE when Gc_cap_cmpt=1.
  - S_DONE stays until cap_en=0, which takes it to S_IDLE.
  - ADC strobes are ignored in S_IDLE and S_DONE.
- Pairing in S_RUN:
  - adc0_valid loads r0 and sets h0; adc1_valid loads r1 and sets h1.
  - Pair completes in a cycle where (h0|adc0_valid) & (h1|adc1_valid). Fresh input takes priority over the held register.
  - The word {ch1, ch0} is pushed and h0/h1 are cleared on the same edge.
  - Both strobes in the same cycle with nothing held: pushed directly.
  - Strobe on a channel already held, with no partner this cycle: overwrite the held value, keep the flag set, set skew_err.
- FIFO:
  - Push when a pair completes and the FIFO is not full, or it is full and a pop occurs in the same cycle.
  - Otherwise the pair is dropped and ovf is set.
  - Pop = Gc_mereg_datv & Gc_mereg_datr.
  - Gc_mereg_datv = !empty. Gc_merge_data = head word, combinational from the read pointer.
  - Gc_merge_data is stable while datv=1 and datr=0.
  - Gc_mereg_datr while datv=0 has no effect.
  - Pointers wrap modulo depth. fifo_level counts 0..16: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Latency: pair completes on edge N; Gc_mereg_datv=1 and the word is on Gc_merge_data in cycle N+1.
- Gc_cap_cmpt:
  - On the first cycle it is seen in S_RUN: no push that cycle, FIFO flushed (pointers zeroed), h0/h1 cleared.
  - Next cycle Gc_mereg_datv=0.
  - ovf and skew_err hold until cleared by reset or cap_en.
- Reset or cap_en=0 mid-transfer: any queued words are discarded immediately, with no partial-word output.

Decomposition:
- Package tc_pl_cap_pkg:
  - state encodings S_IDLE=0, S_RUN=1, S_DONE=2;
  - ADC_W/ADC0_1 defaults;
  - FIFO depth constant.
- One sub-module, tc_pl_cap_fifo_fwft: sync FWFT FIFO with synchronous flush input and a level output.
- Pairing logic and FSM stay in the top module.

Test Plan:
1. cap_en=1; adc0=0x0000001 and adc1=0x0000002 in the same cycle; datr=1 -> next cycle datv=1 with data=0x00000020000001, held exactly 1 cycle; level returns to 0.
2. adc0=0xAAAAAAA at t, adc1=0x5555555 at t+3 -> one word 0x5555555AAAAAAA, datv rises at t+4; skew_err=0.
3. datr=0; push 17 pairs (ch0=i, ch1=i+0x100) -> level=16, ovf=1; then datr=1 -> words i=0..15 emerge in order, level drops to 0.
4. adc0=0x1 then adc0=0x2 with no adc1; then adc1=0x3 -> skew_err=1, single word 0x00000030000002.
5. 5 words queued with datr=0; Gc_cap_cmpt=1 -> next cycle datv=0, level=0; further strobes ignored; cap_en 0->1 resumes normal pairing.
6. rst=1 for 1 cycle with 3 words queued and h0 set -> all outputs at reset values; next pair after rst is correct with no stale ch0.
